// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: FSM states, opcodes and flag-update masks.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2
  } state_e;

  localparam logic [3:0] OpAdc = 4'h0;
  localparam logic [3:0] OpSbc = 4'h1;
  localparam logic [3:0] OpAnd = 4'h2;
  localparam logic [3:0] OpOra = 4'h3;
  localparam logic [3:0] OpEor = 4'h4;
  localparam logic [3:0] OpLsr = 4'h5;
  localparam logic [3:0] OpRor = 4'h6;
  localparam logic [3:0] OpAsl = 4'h7;
  localparam logic [3:0] OpRol = 4'h8;
  localparam logic [3:0] OpCmp = 4'h9;
  localparam logic [3:0] OpInc = 4'hA;
  localparam logic [3:0] OpDec = 4'hB;

  // Update masks, bit order {N,Z,C,V}
  localparam logic [3:0] UpdNzcv = 4'b1111;
  localparam logic [3:0] UpdNzc  = 4'b1110;
  localparam logic [3:0] UpdNz   = 4'b1100;
  localparam logic [3:0] UpdNone = 4'b0000;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OpDec;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, ALU-control and result signals of the ALU sequencer.
interface alu_sequencer_if;
  logic       i_start;
  logic       o_ready;
  logic [3:0] i_op;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       i_c;
  logic [7:0] o_sb;
  logic [7:0] o_db;
  logic       o_sb_add;
  logic       o_db_add;
  logic       o_db_n_add;
  logic       o_0_add;
  logic       o_1_addc;
  logic       o_sums;
  logic       o_ands;
  logic       o_eors;
  logic       o_ors;
  logic       o_srs;
  logic [7:0] i_add;
  logic       o_done;
  logic [7:0] o_result;
  logic       o_n;
  logic       o_z;
  logic       o_c;
  logic       o_v;
  logic [3:0] o_upd;
  logic       o_wr;
  logic       o_err;

  modport slave (
    input  i_start, i_op, i_a, i_b, i_c, i_add,
    output o_ready, o_sb, o_db, o_sb_add, o_db_add, o_db_n_add, o_0_add, o_1_addc,
           o_sums, o_ands, o_eors, o_ors, o_srs, o_done, o_result,
           o_n, o_z, o_c, o_v, o_upd, o_wr, o_err
  );

  modport master (
    output i_start, i_op, i_a, i_b, i_c, i_add,
    input  o_ready, o_sb, o_db, o_sb_add, o_db_add, o_db_n_add, o_0_add, o_1_addc,
           o_sums, o_ands, o_eors, o_ors, o_srs, o_done, o_result,
           o_n, o_z, o_c, o_v, o_upd, o_wr, o_err
  );
endinterface

// File: rtl/alu_seq_flags.sv
// Combinational flag, update-mask and write-back computation from registered operands and result.
module alu_seq_flags
  import alu_seq_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [7:0] r_i,
  output logic       n_o,
  output logic       z_o,
  output logic       c_o,
  output logic       v_o,
  output logic [3:0] upd_o,
  output logic       wr_o
);

  logic [7:0] y;
  logic       sum_op;

  always_comb begin
    y      = 8'h00;
    sum_op = 1'b0;
    c_o    = 1'b0;
    v_o    = 1'b0;
    upd_o  = UpdNone;
    wr_o   = 1'b1;
    n_o    = r_i[7];
    z_o    = (r_i == 8'h00);
    case (op_i)
      OpAdc:               begin y = b_i;   sum_op = 1'b1; upd_o = UpdNzcv; end
      OpSbc:               begin y = ~b_i;  sum_op = 1'b1; upd_o = UpdNzcv; end
      OpCmp:               begin y = ~b_i;  sum_op = 1'b1; upd_o = UpdNzc; wr_o = 1'b0; end
      OpAnd, OpOra, OpEor: upd_o = UpdNz;
      OpLsr, OpRor:        begin c_o = a_i[0]; upd_o = UpdNzc; end
      // A+A: the sum carry formula reduces to A[7]
      OpAsl, OpRol:        begin y = a_i;   sum_op = 1'b1; upd_o = UpdNzc; end
      OpInc:               begin y = 8'h00; sum_op = 1'b1; upd_o = UpdNz; end
      OpDec:               begin y = 8'hFF; sum_op = 1'b1; upd_o = UpdNz; end
      default:             wr_o = 1'b0;
    endcase
    if (sum_op) begin
      c_o = (a_i[7] & y[7]) | ((a_i[7] | y[7]) & ~r_i[7]);
      v_o = (a_i[7] == y[7]) & (r_i[7] != a_i[7]);
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation per request: drives ALU controls in EXEC, captures result and flags.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset_n,
  alu_sequencer_if.slave  bus
);

  state_e     state_q, state_d;
  logic [3:0] op_q;
  logic [7:0] a_q, b_q;
  logic       c_q;
  logic [7:0] result_q;
  logic       n_q, z_q, cf_q, v_q;
  logic [3:0] upd_q;
  logic       wr_q, err_q;

  logic       ready, accept;
  logic [7:0] sb, db, r;
  logic       sb_add, db_add, db_n_add, zero_add, one_addc;
  logic       sums, ands, eors, ors, srs;
  logic       f_n, f_z, f_c, f_v, f_wr;
  logic [3:0] f_upd;

  assign ready  = (state_q != StExec);
  assign accept = bus.i_start & ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = accept ? StExec : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sb = 8'h00; db = 8'h00;
    sb_add = 1'b0; db_add = 1'b0; db_n_add = 1'b0; zero_add = 1'b0; one_addc = 1'b0;
    sums = 1'b0; ands = 1'b0; eors = 1'b0; ors = 1'b0; srs = 1'b0;
    if (state_q == StExec && op_legal(op_q)) begin
      sb     = a_q;
      sb_add = 1'b1;
      case (op_q)
        OpAdc:        begin db = b_q; db_add = 1'b1; sums = 1'b1; one_addc = c_q; end
        OpSbc:        begin db = b_q; db_n_add = 1'b1; sums = 1'b1; one_addc = c_q; end
        OpCmp:        begin db = b_q; db_n_add = 1'b1; sums = 1'b1; one_addc = 1'b1; end
        OpAnd:        begin db = b_q; db_add = 1'b1; ands = 1'b1; end
        OpOra:        begin db = b_q; db_add = 1'b1; ors = 1'b1; end
        OpEor:        begin db = b_q; db_add = 1'b1; eors = 1'b1; end
        OpAsl:        begin db = a_q; db_add = 1'b1; sums = 1'b1; end
        OpRol:        begin db = a_q; db_add = 1'b1; sums = 1'b1; one_addc = c_q; end
        OpLsr:        srs = 1'b1;
        OpRor:        begin srs = 1'b1; one_addc = c_q; end
        OpInc:        begin db = 8'h00; db_add = 1'b1; sums = 1'b1; one_addc = 1'b1; end
        OpDec:        begin db = 8'hFF; db_add = 1'b1; sums = 1'b1; end
        default:      ;
      endcase
    end
  end

  // Illegal opcodes ignore the ALU and report a zero result
  assign r = op_legal(op_q) ? bus.i_add : 8'h00;

  alu_seq_flags u_flags (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .r_i   (r),
    .n_o   (f_n),
    .z_o   (f_z),
    .c_o   (f_c),
    .v_o   (f_v),
    .upd_o (f_upd),
    .wr_o  (f_wr)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      op_q     <= 4'h0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      c_q      <= 1'b0;
      result_q <= 8'h00;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      cf_q     <= 1'b0;
      v_q      <= 1'b0;
      upd_q    <= 4'h0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= bus.i_op;
        a_q  <= bus.i_a;
        b_q  <= bus.i_b;
        c_q  <= bus.i_c;
      end
      if (state_q == StExec) begin
        result_q <= r;
        n_q      <= f_n;
        z_q      <= f_z;
        cf_q     <= f_c;
        v_q      <= f_v;
        upd_q    <= f_upd;
        wr_q     <= f_wr;
        err_q    <= ~op_legal(op_q);
      end
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_sb       = sb;
  assign bus.o_db       = db;
  assign bus.o_sb_add   = sb_add;
  assign bus.o_db_add   = db_add;
  assign bus.o_db_n_add = db_n_add;
  assign bus.o_0_add    = zero_add;
  assign bus.o_1_addc   = one_addc;
  assign bus.o_sums     = sums;
  assign bus.o_ands     = ands;
  assign bus.o_eors     = eors;
  assign bus.o_ors      = ors;
  assign bus.o_srs      = srs;
  assign bus.o_done     = (state_q == StWb);
  assign bus.o_err      = (state_q == StWb) & err_q;
  assign bus.o_result   = result_q;
  assign bus.o_n        = n_q;
  assign bus.o_z        = z_q;
  assign bus.o_c        = cf_q;
  assign bus.o_v        = v_q;
  assign bus.o_upd      = upd_q;
  assign bus.o_wr       = wr_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU that latches on falling clock.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  logic [7:0] alu_a, alu_b, alu_y;
  logic [8:0] alu_sum;
  always_comb begin
    alu_a   = (bus.o_sb_add && !bus.o_0_add) ? bus.o_sb : 8'h00;
    alu_b   = bus.o_db_add ? bus.o_db : (bus.o_db_n_add ? ~bus.o_db : 8'h00);
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, bus.o_1_addc};
    alu_y   = 8'h00;
    if (bus.o_sums)      alu_y = alu_sum[7:0];
    else if (bus.o_ands) alu_y = alu_a & alu_b;
    else if (bus.o_eors) alu_y = alu_a ^ alu_b;
    else if (bus.o_ors)  alu_y = alu_a | alu_b;
    else if (bus.o_srs)  alu_y = {bus.o_1_addc, alu_a[7:1]};
  end
  always @(negedge clk) bus.i_add <= alu_y;

  logic [25:0] ctrl;
  assign ctrl = {bus.o_sb, bus.o_db, bus.o_sb_add, bus.o_db_add, bus.o_db_n_add, bus.o_0_add,
                 bus.o_1_addc, bus.o_sums, bus.o_ands, bus.o_eors, bus.o_ors, bus.o_srs};

  typedef struct {
    logic [7:0] result;
    logic [3:0] flags;
    logic [3:0] upd;
    logic       wr;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_prev = -1;
  int   done_last = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic c);
    exp_t       e;
    logic [8:0] s;
    logic [7:0] nb, r;
    logic       cf, vf;
    nb = ~b; s = 9'h0; r = 8'h00; cf = 1'b0; vf = 1'b0;
    e.err = 1'b0; e.wr = 1'b1; e.upd = 4'b0000; e.cyc = 0;
    case (op)
      OpAdc: begin
        s = {1'b0, a} + {1'b0, b} + {8'h00, c}; r = s[7:0]; cf = s[8];
        vf = (a[7] == b[7]) && (r[7] != a[7]); e.upd = 4'b1111;
      end
      OpSbc, OpCmp: begin
        s = {1'b0, a} + {1'b0, nb} + {8'h00, (op == OpCmp) ? 1'b1 : c}; r = s[7:0]; cf = s[8];
        vf = (a[7] != b[7]) && (r[7] != a[7]);
        e.upd = (op == OpCmp) ? 4'b1110 : 4'b1111;
        e.wr  = (op != OpCmp);
      end
      OpAnd: begin r = a & b; e.upd = 4'b1100; end
      OpOra: begin r = a | b; e.upd = 4'b1100; end
      OpEor: begin r = a ^ b; e.upd = 4'b1100; end
      OpLsr: begin r = {1'b0, a[7:1]}; cf = a[0]; e.upd = 4'b1110; end
      OpRor: begin r = {c, a[7:1]};    cf = a[0]; e.upd = 4'b1110; end
      OpAsl: begin r = {a[6:0], 1'b0}; cf = a[7]; e.upd = 4'b1110; end
      OpRol: begin r = {a[6:0], c};    cf = a[7]; e.upd = 4'b1110; end
      OpInc: begin r = a + 8'h01; e.upd = 4'b1100; end
      OpDec: begin r = a - 8'h01; e.upd = 4'b1100; end
      default: begin r = 8'h00; e.wr = 1'b0; e.err = 1'b1; end
    endcase
    e.result = r;
    e.flags  = {r[7], (r == 8'h00), cf, vf} & e.upd;
    return e;
  endfunction

  // Monitor: pops on o_done, pushes on accept, both sampled on the falling edge
  initial begin
    exp_t e;
    logic exec_pending;
    exec_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        exec_pending = 1'b0;
      end else begin
        if (exec_pending) begin
          check("ready_in_exec", 32'(bus.o_ready), 32'd0);
          exec_pending = 1'b0;
        end
        if (bus.o_err && !bus.o_done) check("err_outside_wb", 32'(bus.o_err), 32'd0);
        if (bus.o_done) begin
          if (q.size() == 0) begin
            check("spurious_done", 32'(bus.o_done), 32'd0);
          end else begin
            e = q.pop_front();
            check("result", 32'(bus.o_result), 32'(e.result));
            check("flags", 32'({bus.o_n, bus.o_z, bus.o_c, bus.o_v} & e.upd), 32'(e.flags));
            check("upd", 32'(bus.o_upd), 32'(e.upd));
            check("wr", 32'(bus.o_wr), 32'(e.wr));
            check("err", 32'(bus.o_err), 32'(e.err));
            check("latency", 32'(cyc - e.cyc), 32'd2);
            check("ready_in_wb", 32'(bus.o_ready), 32'd1);
            check("ctrl_in_wb", 32'(ctrl), 32'd0);
          end
          done_prev = done_last;
          done_last = cyc;
        end
        if (bus.i_start && bus.o_ready) begin
          e = model(bus.i_op, bus.i_a, bus.i_b, bus.i_c);
          e.cyc = cyc;
          q.push_back(e);
          exec_pending = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic c);
    bus.i_op = op; bus.i_a = a; bus.i_b = b; bus.i_c = c;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) check("timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic c);
    exp_t m;
    m = model(op, a, b, c);
    @(posedge clk); #1;
    drive(op, a, b, c);
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    wait_idle();
    check("hold_result", 32'(bus.o_result), 32'(m.result));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
    check({tag, "_done"}, 32'(bus.o_done), 32'd0);
    check({tag, "_err"}, 32'(bus.o_err), 32'd0);
    check({tag, "_result"}, 32'(bus.o_result), 32'd0);
    check({tag, "_flags"}, 32'({bus.o_n, bus.o_z, bus.o_c, bus.o_v}), 32'd0);
    check({tag, "_upd_wr"}, 32'({bus.o_upd, bus.o_wr}), 32'd0);
    check({tag, "_ctrl"}, 32'(ctrl), 32'd0);
  endtask

  initial begin
    bus.i_start = 1'b0;
    drive(4'h0, 8'h00, 8'h00, 1'b0);
    #2;
    check_reset_state("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(OpAdc, 8'h50, 8'h50, 1'b0);
    run_op(OpSbc, 8'h50, 8'hF0, 1'b1);
    run_op(OpCmp, 8'h40, 8'h40, 1'b0);
    run_op(OpRor, 8'h01, 8'h00, 1'b1);
    run_op(OpDec, 8'h00, 8'h00, 1'b0);
    run_op(OpAnd, 8'hF0, 8'h3C, 1'b0);
    run_op(OpOra, 8'h00, 8'h00, 1'b1);
    run_op(OpEor, 8'hAA, 8'hFF, 1'b0);
    run_op(OpLsr, 8'h81, 8'h00, 1'b1);
    run_op(OpAsl, 8'hC0, 8'h00, 1'b1);
    run_op(OpRol, 8'h40, 8'h00, 1'b1);
    run_op(OpInc, 8'hFF, 8'h00, 1'b0);
    run_op(OpAdc, 8'hFF, 8'h01, 1'b1);
    run_op(4'hF, 8'h12, 8'h34, 1'b1);

    // Back-to-back: start held high through EXEC
    @(posedge clk); #1;
    drive(OpAdc, 8'h12, 8'h34, 1'b1);
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    drive(OpAnd, 8'hF0, 8'h3C, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    wait_idle();
    check("b2b_spacing", 32'(done_last - done_prev), 32'd2);

    // Reset asserted mid-EXEC
    @(posedge clk); #1;
    drive(OpAdc, 8'h01, 8'h01, 1'b0);
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    check("pre_rst_exec", 32'(bus.o_sums), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_done", 32'(done_last), 32'(done_prev + 2));
    run_op(OpInc, 8'h7F, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
